peripheral_gpio_filter_bb: RTL
==============================

PERIPHERAL_GPIO_FILTER_BB -- requirements
Module: peripheral_gpio_filter_bb

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the number of GPIO input lines.
REQ-002 The block SHALL have parameter CNT_W, default 8, giving the debounce counter width per line.
REQ-003 Port clk  input  1  receiving clock; all state updates on posedge.
REQ-004 Port rst  input  1  asynchronous, active-low reset.
REQ-005 Port data_in  input  WIDTH  per-line input, already synchronized to clk by the upstream two-flop cell.
REQ-006 Port dbnc_limit  input  CNT_W  debounce threshold, quasi-static, shared by all lines.
REQ-007 Port irq_en  input  WIDTH  per-line interrupt enable.
REQ-008 Port irq_edge  input  WIDTH  per-line edge select: 0 = rising, 1 = falling.
REQ-009 Port irq_clr  input  WIDTH  per-line single-cycle clear pulse (write-1-to-clear).
REQ-010 Port data_out  output  WIDTH  debounced line state.
REQ-011 Port irq_flag  output  WIDTH  per-line sticky interrupt flags.
REQ-012 Port irq  output  1  OR-reduction of irq_flag & irq_en, combinational from registers.

Function
REQ-013 Each line SHALL own an independent CNT_W-bit counter cnt[i].
- data_in[i] == data_out[i]: cnt[i] <= 0.
- data_in[i] != data_out[i] and cnt[i] == dbnc_limit: data_out[i] <= data_in[i], cnt[i] <= 0.
- Otherwise: cnt[i] <= cnt[i] + 1.
REQ-014 A change held for dbnc_limit+1 consecutive samples SHALL appear on data_out exactly dbnc_limit+1 clocks after the first differing sample; any earlier reversion SHALL restart the count from 0 and leave data_out unchanged.
REQ-015 dbnc_limit = 0 SHALL give a plain one-clock register from data_in to data_out.
REQ-016 cnt[i] SHALL never wrap, because the cnt[i] == dbnc_limit check terminates counting at dbnc_limit <= 2^CNT_W-1.
REQ-017 dbnc_limit lowered below a running cnt[i] SHALL produce no wrap: cnt[i] saturates at all-ones, then reloads to 0 on the next input match.
REQ-018 A qualified edge SHALL be a data_out[i] transition in the cycle it registers:
- 0->1 when irq_edge[i] = 0.
- 1->0 when irq_edge[i] = 1.
REQ-019 A qualified edge with irq_en[i] = 1 SHALL set irq_flag[i] on that same clock edge.
REQ-020 A qualified edge with irq_en[i] = 0 SHALL leave irq_flag[i] unchanged.
REQ-021 irq_clr[i] = 1 SHALL clear irq_flag[i] on the next clock edge.
REQ-022 A set and an irq_clr[i] in the same cycle SHALL resolve with the set winning.
REQ-023 Deasserting irq_en[i] SHALL mask irq without clearing irq_flag[i].

Reset
REQ-024 While rst = 0, data_out, irq_flag and every cnt SHALL be 0, so irq = 0, asynchronously and without waiting for clk.
REQ-025 Reset asserted mid-debounce SHALL discard partial counts.
REQ-026 After reset release, no edge SHALL be reported against the reset value of data_out unless the debounce rules of REQ-013 produce a transition.

Configuration
REQ-027 With macro PERIPHERAL_GPIO_DEBOUNCE_EN defined, counters and dbnc_limit SHALL behave per REQ-013 to REQ-017.
REQ-028 Without PERIPHERAL_GPIO_DEBOUNCE_EN:
- No counters SHALL be instantiated.
- dbnc_limit SHALL be ignored.
- data_out SHALL be data_in registered by one clock.
- Edge and interrupt logic SHALL be unchanged.

Verification
REQ-029 With dbnc_limit = 3 and data_in[0] 0->1 held: data_out[0] = 1 exactly 4 clocks after the first 1 sample; with irq_en[0] = 1 and irq_edge[0] = 0, irq_flag[0] and irq are 1 in the same cycle.
REQ-030 With dbnc_limit = 3, a glitch of 1 held 3 cycles then 0: data_out[0] stays 0 and irq_flag stays 0.
REQ-031 With irq_edge[1] = 1 and a debounced 1->0 on line 1 coinciding with irq_clr[1] = 1: irq_flag[1] = 1 after the edge (set wins); a later solitary irq_clr[1] pulse clears it.
REQ-032 With irq_en[2] = 0 and a qualified edge on line 2: irq_flag[2] = 0 and irq = 0.
REQ-033 With rst asserted two clocks into a count of dbnc_limit = 5: all outputs 0 immediately; after release the input needs a full 6 samples to propagate.
REQ-034 Built without PERIPHERAL_GPIO_DEBOUNCE_EN and dbnc_limit = 200: data_out follows data_in with 1-clock latency.

Source files
------------

// File: rtl/peripheral_gpio_filter_bb.sv
// GPIO input filter: per-line debounce, edge detect and sticky interrupt flags.
// Optional macro PERIPHERAL_GPIO_DEBOUNCE_EN enables the per-line debounce
// counters. When it is undefined, data_out is data_in delayed by one clock and
// dbnc_limit is ignored.

module peripheral_gpio_filter_lane #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             din_i,
    input  logic [CNT_W-1:0] dbnc_limit_i,
    input  logic             irq_en_i,
    input  logic             irq_edge_i,
    input  logic             irq_clr_i,
    output logic             dout_o,
    output logic             flag_o
);

    logic dout_q, dout_d;
    logic flag_q, flag_d;
    logic qual_edge;

`ifdef PERIPHERAL_GPIO_DEBOUNCE_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Debounce: count consecutive mismatching samples. Accept the new level
    // when the count reaches the limit. Saturate at all-ones if the limit was
    // lowered below a running count.
    always_comb begin
        cnt_d  = cnt_q;
        dout_d = dout_q;
        if (din_i == dout_q) begin
            cnt_d = '0;
        end else if (cnt_q == dbnc_limit_i) begin
            dout_d = din_i;
            cnt_d  = '0;
        end else if (cnt_q != '1) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Counter register. Reset discards any partial count.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) cnt_q <= '0;
        else      cnt_q <= cnt_d;
    end
`else
    logic unused_limit;
    assign unused_limit = ^dbnc_limit_i;

    // Without debounce, the line is a plain one-clock register.
    always_comb begin
        dout_d = din_i;
    end
`endif

    // Edge qualify on the registered transition. A set beats a same-cycle clear.
    always_comb begin
        qual_edge = irq_edge_i ? (dout_q & ~dout_d) : (~dout_q & dout_d);
        flag_d    = flag_q;
        if (irq_clr_i)             flag_d = 1'b0;
        if (qual_edge && irq_en_i) flag_d = 1'b1;
    end

    // Output level and sticky flag registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dout_q <= 1'b0;
            flag_q <= 1'b0;
        end else begin
            dout_q <= dout_d;
            flag_q <= flag_d;
        end
    end

    assign dout_o = dout_q;
    assign flag_o = flag_q;

endmodule

module peripheral_gpio_filter_bb #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] data_in,
    input  logic [CNT_W-1:0] dbnc_limit,
    input  logic [WIDTH-1:0] irq_en,
    input  logic [WIDTH-1:0] irq_edge,
    input  logic [WIDTH-1:0] irq_clr,
    output logic [WIDTH-1:0] data_out,
    output logic [WIDTH-1:0] irq_flag,
    output logic             irq
);

    for (genvar i = 0; i < WIDTH; i++) begin : g_lane
        peripheral_gpio_filter_lane #(.CNT_W(CNT_W)) u_lane (
            .clk          (clk),
            .rst          (rst),
            .din_i        (data_in[i]),
            .dbnc_limit_i (dbnc_limit),
            .irq_en_i     (irq_en[i]),
            .irq_edge_i   (irq_edge[i]),
            .irq_clr_i    (irq_clr[i]),
            .dout_o       (data_out[i]),
            .flag_o       (irq_flag[i])
        );
    end

    assign irq = |(irq_flag & irq_en);

endmodule
